l1_d_writeback_buffer: RTL and testbench

//  Write-back path from the L1 D-cache to L2: the reverse direction of the L2->L1 refill.

---
 rtl/l1_d_writeback_buffer_pkg.sv | 18 +
 rtl/l1_d_writeback_buffer_fifo.sv | 85 ++++++++
 rtl/l1_d_writeback_buffer.sv | 98 +++++++++
 tb/tb_l1_d_writeback_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1_d_writeback_buffer_pkg.sv
// Shared L1 D-cache write-back definitions: block geometry, write-back FSM encoding and entry layout.
package l1_d_writeback_buffer_pkg;

    localparam int L1_BLOCK_ADDR_W = 26;
    localparam int L1_BLOCK_DATA_W = 512;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_SEND = 2'd1,
        WB_GAP  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [L1_BLOCK_ADDR_W-1:0] addr;
        logic [L1_BLOCK_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/l1_d_writeback_buffer_fifo.sv
// Circular write-back queue with per-entry valid bits and a youngest-match address lookup.
module l1_d_wb_fifo
    import l1_d_writeback_buffer_pkg::*;
#(
    parameter int ADDR_W = L1_BLOCK_ADDR_W,
    parameter int DATA_W = L1_BLOCK_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  idx;

    // Control state only; push never targets the head slot while it is occupied.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

    // Walk oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && (addr_mem[idx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/l1_d_writeback_buffer.sv
// L1 D-cache to L2 write-back buffer: queues dirty victims, sends them over req/ack, forwards refill hits.
module l1_d_writeback_buffer
    import l1_d_writeback_buffer_pkg::*;
#(
    parameter int ADDR_W = L1_BLOCK_ADDR_W,
    parameter int DATA_W = L1_BLOCK_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              evict_valid,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [DATA_W-1:0] evict_data,
    output logic              evict_ready,
    output logic              stall_L1,
    output logic              wb_req_L2,
    output logic [ADDR_W-1:0] wb_addr_L2,
    output logic [DATA_W-1:0] wb_data_L2,
    input  logic              wb_ack_L2,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data
);

    wb_state_e         state;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Readiness comes from the registered count, so a pop never frees a slot in the same cycle.
    assign evict_ready = ~full;
    assign stall_L1    = evict_valid & full;
    assign push        = evict_valid & ~full;
    assign pop         = (state == WB_SEND) & wb_ack_L2;

    l1_d_wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .nrst        (nrst),
        .push        (push),
        .push_addr   (evict_addr),
        .push_data   (evict_data),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (full),
        .empty       (empty),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
    );

    // Head entry cannot change while requesting, so gating it with req keeps the bus stable until ack.
    assign wb_addr_L2 = wb_req_L2 ? head_addr : '0;
    assign wb_data_L2 = wb_req_L2 ? head_data : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= WB_IDLE;
            wb_req_L2 <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (!empty) begin
                        state     <= WB_SEND;
                        wb_req_L2 <= 1'b1;
                    end
                end
                WB_SEND: begin
                    if (wb_ack_L2) begin
                        state     <= WB_GAP;
                        wb_req_L2 <= 1'b0;
                    end
                end
                WB_GAP: begin
                    if (!empty) begin
                        state     <= WB_SEND;
                        wb_req_L2 <= 1'b1;
                    end else begin
                        state     <= WB_IDLE;
                        wb_req_L2 <= 1'b0;
                    end
                end
                default: begin
                    state     <= WB_IDLE;
                    wb_req_L2 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_d_writeback_buffer.sv
// Directed bench for l1_d_writeback_buffer with a scoreboard of expected L2 write-backs.
module tb_l1_d_writeback_buffer;
    import l1_d_writeback_buffer_pkg::*;

    localparam int AW = L1_BLOCK_ADDR_W;
    localparam int DW = L1_BLOCK_DATA_W;

    logic          clk = 1'b0;
    logic          nrst;
    logic          evict_valid;
    logic [AW-1:0] evict_addr;
    logic [DW-1:0] evict_data;
    logic          evict_ready;
    logic          stall_L1;
    logic          wb_req_L2;
    logic [AW-1:0] wb_addr_L2;
    logic [DW-1:0] wb_data_L2;
    logic          wb_ack_L2;
    logic [AW-1:0] lookup_addr;
    logic          lookup_hit;
    logic [DW-1:0] lookup_data;

    int        vectors = 0;
    int        errors  = 0;
    wb_entry_t sb[$];

    l1_d_writeback_buffer dut (
        .clk         (clk),
        .nrst        (nrst),
        .evict_valid (evict_valid),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data),
        .evict_ready (evict_ready),
        .stall_L1    (stall_L1),
        .wb_req_L2   (wb_req_L2),
        .wb_addr_L2  (wb_addr_L2),
        .wb_data_L2  (wb_data_L2),
        .wb_ack_L2   (wb_ack_L2),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one eviction that the buffer is known to accept and record it as an expected write-back.
    task automatic push_blk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_entry_t e;
        evict_valid = 1'b1;
        evict_addr  = a;
        evict_data  = d;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
        @(posedge clk); #1;
        evict_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_req_L2 && n < 20);
        chk({tag, "_req"}, DW'(wb_req_L2), DW'(1'b1));
    endtask

    task automatic check_head(input string tag);
        wb_entry_t e;
        if (sb.size() == 0) begin
            vectors++;
            errors++;
            $error("FAIL %s_sb: observed request expected empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_addr"}, DW'(wb_addr_L2), DW'(e.addr));
            chk({tag, "_data"}, wb_data_L2, e.data);
        end
    endtask

    task automatic drain_one(input string tag);
        wait_req(tag);
        check_head(tag);
        wb_ack_L2 = 1'b1;
        @(posedge clk); #1;
        wb_ack_L2 = 1'b0;
    endtask

    initial begin
        nrst        = 1'b0;
        evict_valid = 1'b1;
        evict_addr  = 26'h5;
        evict_data  = 512'h55;
        wb_ack_L2   = 1'b0;
        lookup_addr = 26'h5;

        // Reset with a victim presented
        repeat (3) @(negedge clk);
        chk("rst_ready", DW'(evict_ready), DW'(1'b1));
        chk("rst_stall", DW'(stall_L1), DW'(1'b0));
        chk("rst_req",   DW'(wb_req_L2), DW'(1'b0));
        chk("rst_hit",   DW'(lookup_hit), DW'(1'b0));
        evict_valid = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        @(negedge clk);
        chk("idle_req",  DW'(wb_req_L2), DW'(1'b0));
        chk("idle_addr", DW'(wb_addr_L2), '0);
        chk("idle_data", wb_data_L2, '0);
        chk("idle_hit",  DW'(lookup_hit), DW'(1'b0));
        @(posedge clk); #1;

        // Single write-back: request appears two edges after the push
        push_blk(26'h0000A5, 512'h1234);
        @(negedge clk);
        chk("t2_req_early", DW'(wb_req_L2), DW'(1'b0));
        lookup_addr = 26'h0000A5;
        #1;
        chk("t2_lk_hit",  DW'(lookup_hit), DW'(1'b1));
        chk("t2_lk_data", lookup_data, 512'h1234);
        @(negedge clk);
        chk("t2_req_on", DW'(wb_req_L2), DW'(1'b1));
        drain_one("t2");
        @(negedge clk);
        chk("t2_gap_req",  DW'(wb_req_L2), DW'(1'b0));
        chk("t2_gap_addr", DW'(wb_addr_L2), '0);
        @(negedge clk);
        chk("t2_idle_req", DW'(wb_req_L2), DW'(1'b0));
        chk("t2_lk_gone",  DW'(lookup_hit), DW'(1'b0));
        chk("t2_ready",    DW'(evict_ready), DW'(1'b1));
        @(posedge clk); #1;

        // Fill and stall; the third victim waits until one cycle after the pop
        push_blk(26'h10, 512'hA10);
        push_blk(26'h11, 512'hA11);
        evict_valid = 1'b1;
        evict_addr  = 26'h12;
        evict_data  = 512'hA12;
        sb.push_back('{addr: 26'h12, data: 512'hA12});
        @(negedge clk);
        chk("t3_full_ready", DW'(evict_ready), DW'(1'b0));
        chk("t3_stall",      DW'(stall_L1), DW'(1'b1));
        drain_one("t3_a");
        @(negedge clk);
        chk("t3_ready_back", DW'(evict_ready), DW'(1'b1));
        chk("t3_stall_off",  DW'(stall_L1), DW'(1'b0));
        @(posedge clk); #1;
        evict_valid = 1'b0;
        drain_one("t3_b");
        drain_one("t3_c");
        @(negedge clk);
        chk("t3_empty_req", DW'(wb_req_L2), DW'(1'b0));
        @(posedge clk); #1;

        // Push in the same cycle as the ack keeps one entry queued
        push_blk(26'h1F, 512'hB1F);
        wait_req("t4_a");
        check_head("t4_a");
        wb_ack_L2   = 1'b1;
        evict_valid = 1'b1;
        evict_addr  = 26'h20;
        evict_data  = 512'hB20;
        sb.push_back('{addr: 26'h20, data: 512'hB20});
        @(posedge clk); #1;
        wb_ack_L2   = 1'b0;
        evict_valid = 1'b0;
        lookup_addr = 26'h20;
        @(negedge clk);
        chk("t4_gap_req", DW'(wb_req_L2), DW'(1'b0));
        chk("t4_ready",   DW'(evict_ready), DW'(1'b1));
        chk("t4_lk_hit",  DW'(lookup_hit), DW'(1'b1));
        @(negedge clk);
        chk("t4_resend", DW'(wb_req_L2), DW'(1'b1));
        drain_one("t4_b");
        @(posedge clk); #1;

        // Two copies of one block: lookup returns the younger data
        push_blk(26'h30, 512'hDA7A_A);
        push_blk(26'h30, 512'hDA7A_B);
        lookup_addr = 26'h30;
        @(negedge clk);
        chk("t5_hit",  DW'(lookup_hit), DW'(1'b1));
        chk("t5_data", lookup_data, 512'hDA7A_B);
        lookup_addr = 26'h31;
        #1;
        chk("t5_miss_hit",  DW'(lookup_hit), DW'(1'b0));
        chk("t5_miss_data", lookup_data, '0);
        lookup_addr = 26'h30;
        drain_one("t5_a");
        @(negedge clk);
        chk("t5_hit_after", DW'(lookup_hit), DW'(1'b1));
        chk("t5_data_after", lookup_data, 512'hDA7A_B);
        drain_one("t5_b");
        @(negedge clk);
        chk("t5_gone", DW'(lookup_hit), DW'(1'b0));
        @(posedge clk); #1;

        // Reset while requesting with two entries queued
        push_blk(26'h40, 512'hC40);
        push_blk(26'h41, 512'hC41);
        lookup_addr = 26'h40;
        wait_req("t6_pre");
        #2;
        nrst = 1'b0;
        #1;
        chk("t6_req_drop", DW'(wb_req_L2), DW'(1'b0));
        chk("t6_addr",     DW'(wb_addr_L2), '0);
        chk("t6_ready",    DW'(evict_ready), DW'(1'b1));
        chk("t6_hit",      DW'(lookup_hit), DW'(1'b0));
        sb.delete();
        @(posedge clk); #1;
        nrst      = 1'b1;
        wb_ack_L2 = 1'b1;
        @(posedge clk); #1;
        wb_ack_L2 = 1'b0;
        @(negedge clk);
        chk("t6_spur_req",   DW'(wb_req_L2), DW'(1'b0));
        chk("t6_spur_ready", DW'(evict_ready), DW'(1'b1));
        @(posedge clk); #1;
        push_blk(26'h50, 512'hC50);
        drain_one("t6_post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
